dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 30 +++
 rtl/dmem_byte_merge.sv | 17 +
 rtl/dmem_responder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder: FSM encoding,
// legal lane-enable patterns, memory base address and default depth.
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StResp = 2'd2
   } state_e;

   localparam int unsigned DefaultDepthWords = 3072;
   localparam logic [31:0] DmBaseAddr        = 32'h0000_0000;

   localparam int unsigned NumLegalByteen = 8;
   localparam logic [NumLegalByteen-1:0][3:0] LegalByteen = {
      4'b0000, 4'b1111, 4'b0011, 4'b1100,
      4'b0001, 4'b0010, 4'b0100, 4'b1000
   };

   // Only whole words, aligned halves and single bytes are accepted.
   function automatic logic byteen_legal(input logic [3:0] byteen);
      logic hit;
      hit = 1'b0;
      for (int unsigned i = 0; i < NumLegalByteen; i++) begin
         if (LegalByteen[i] == byteen) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/dmem_byte_merge.sv
// Lane merge: each byte of the result comes from wdata where its byteen bit
// is set, otherwise from the old stored word.
module dmem_byte_merge (
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   input  logic [3:0]  byteen,
   output logic [31:0] merged
);

   always_comb begin
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (byteen[i]) merged[8*i +: 8] = wdata[8*i +: 8];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Single-port data-memory responder: one request at a time, WAIT_CYCLES wait
// states, writes commit and reads capture on the edge that enters RESP.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = DefaultDepthWords,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_byteen,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned IdxW      = $clog2(DEPTH_WORDS);
   localparam logic [32:0] ByteLimit = 33'(DEPTH_WORDS) << 2;
   localparam logic [3:0]  WaitLoad  = 4'(WAIT_CYCLES);

   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [31:0]   addr_q, addr_d;
   logic [3:0]    byteen_q, byteen_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;

   logic [31:0]   mem_q [DEPTH_WORDS];

   logic          accept;
   logic          enter_resp;
   logic [31:0]   acc_addr;
   logic [3:0]    acc_byteen;
   logic [31:0]   acc_wdata;
   logic [31:0]   offset;
   logic [IdxW-1:0] idx;
   logic          in_range;
   logic          acc_err;
   logic          is_write;
   logic          wr_en;
   logic [31:0]   rd_word;
   logic [31:0]   merged;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (req_valid) state_d = (WAIT_CYCLES == 0) ? StResp : StWait;
         StWait: if (cnt_q == 4'd1) state_d = StResp;
         StResp: if (rsp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      req_ready = (state_q == StIdle);
      rsp_valid = (state_q == StResp);
      rsp_rdata = rdata_q;
      rsp_err   = err_q;
   end

   // ----------------------------------------------------------- datapath
   assign accept     = req_valid && (state_q == StIdle);
   assign enter_resp = (state_d == StResp) && (state_q != StResp);

   // With zero wait states the access happens on the accept edge itself,
   // so the live request fields are used instead of the registered copy.
   assign acc_addr   = (state_q == StIdle) ? req_addr   : addr_q;
   assign acc_byteen = (state_q == StIdle) ? req_byteen : byteen_q;
   assign acc_wdata  = (state_q == StIdle) ? req_wdata  : wdata_q;

   assign offset   = acc_addr - DmBaseAddr;
   assign in_range = ({1'b0, offset} < ByteLimit);
   assign idx      = offset[IdxW+1:2];
   assign acc_err  = !in_range || !byteen_legal(acc_byteen);
   assign is_write = |acc_byteen;
   assign wr_en    = enter_resp && is_write && !acc_err;
   assign rd_word  = in_range ? mem_q[idx] : 32'h0;

   dmem_byte_merge u_merge (
      .old_word (rd_word),
      .wdata    (acc_wdata),
      .byteen   (acc_byteen),
      .merged   (merged)
   );

   always_comb begin
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      byteen_d = byteen_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      if (accept) begin
         cnt_d    = WaitLoad;
         addr_d   = req_addr;
         byteen_d = req_byteen;
         wdata_d  = req_wdata;
      end else if (state_q == StWait) begin
         cnt_d = cnt_q - 4'd1;
      end
      if (enter_resp) begin
         rdata_d = (acc_err || is_write) ? 32'h0 : rd_word;
         err_d   = acc_err;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= 4'd0;
         addr_q   <= 32'h0;
         byteen_q <= 4'h0;
         wdata_q  <= 32'h0;
         rdata_q  <= 32'h0;
         err_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         byteen_q <= byteen_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   // ------------------------------------------------------------- memory
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH_WORDS); i++) mem_q[i] <= 32'h0;
      end else if (wr_en) begin
         mem_q[idx] <= merged;
      end
   end

   // --------------------------------------------------------- assertions
   a_ready_excl : assert property (@(posedge clk) disable iff (reset)
      !(req_ready && rsp_valid));
   a_resp_hold : assert property (@(posedge clk) disable iff (reset)
      (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_rdata) && $stable(rsp_err)));

endmodule
